branch_predictor_bimodal_btb: RTL and testbench

- Parametrised direct-mapped branch target buffer (BTB) with a per-entry saturating direction counter (bimodal), for the fetch stage.
- Replaces the static not-taken predictor.
- Registered 1-cycle lookup on fetch PC; trained by resolved branches from execute.
- Flush-driven sequential table invalidation, so the tables can map to RAM-style storage.

---
 rtl/branch_predictor_bimodal_btb.sv | 179 +++++++++++++++++
 tb/tb_branch_predictor_bimodal_btb.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_bimodal_btb.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor_bimodal_btb
//  Description : Direct-mapped branch target buffer with a per-entry
//                saturating direction counter. Registered one-cycle lookup
//                for fetch, training from resolved branches, and a
//                sequential invalidation walk on reset/flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor_bimodal_btb #(
    parameter int XLEN     = 64,
    parameter int ENTRIES  = 16,
    parameter int TAG_BITS = 16,
    parameter int CTR_BITS = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_valid,
    input  logic [XLEN-1:0] fetch_pc,
    output logic            pred_valid,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            update_valid,
    input  logic [XLEN-1:0] update_pc,
    input  logic            update_taken,
    input  logic [XLEN-1:0] update_target,
    input  logic            flush,
    output logic            busy
);

    localparam int c_IDX_BITS = $clog2(ENTRIES);
    localparam logic [0:0] c_ST_CLEAR = 1'b0;
    localparam logic [0:0] c_ST_IDLE  = 1'b1;
    localparam logic [CTR_BITS-1:0] c_CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0] c_CTR_WEAK = CTR_BITS'(1) << (CTR_BITS - 1);
    localparam logic [c_IDX_BITS-1:0] c_PTR_LAST = c_IDX_BITS'(ENTRIES - 1);

    // Table storage; no reset so it can map onto RAM-style arrays
    logic [ENTRIES-1:0]  r_valid;
    logic [TAG_BITS-1:0] r_tag    [ENTRIES];
    logic [XLEN-1:0]     r_target [ENTRIES];
    logic [CTR_BITS-1:0] r_ctr    [ENTRIES];

    logic [0:0]            r_state;
    logic [0:0]            w_state_nxt;
    logic [c_IDX_BITS-1:0] r_ptr;
    logic [c_IDX_BITS-1:0] w_ptr_nxt;
    logic                  w_clear_en;

    logic [c_IDX_BITS-1:0] w_f_idx;
    logic [TAG_BITS-1:0]   w_f_tag;
    logic                  w_f_hit;
    logic                  w_f_taken;
    logic [XLEN-1:0]       w_f_target;

    logic [c_IDX_BITS-1:0] w_u_idx;
    logic [TAG_BITS-1:0]   w_u_tag;
    logic                  w_u_hit;
    logic                  w_u_en;
    logic [CTR_BITS-1:0]   w_ctr_upd;

    // Low PC bits and bits above the tag never take part in index/tag
    logic w_unused_pc;
    assign w_unused_pc = ^{fetch_pc, update_pc};

    assign busy = (r_state == c_ST_CLEAR);

    // Walk state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_CLEAR;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Walk next-state: one entry invalidated per cycle, flush restarts at 0
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_clear_en  = 1'b0;
        case (r_state)
            c_ST_CLEAR: begin
                w_clear_en = 1'b1;
                if (flush) begin
                    w_ptr_nxt = '0;
                end else if (r_ptr == c_PTR_LAST) begin
                    w_state_nxt = c_ST_IDLE;
                    w_ptr_nxt   = '0;
                end else begin
                    w_ptr_nxt = r_ptr + 1'b1;
                end
            end
            c_ST_IDLE: begin
                if (flush) begin
                    w_state_nxt = c_ST_CLEAR;
                    w_ptr_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = c_ST_CLEAR;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    // Lookup path; the walk forces a miss so stale entries are never used
    assign w_f_idx    = fetch_pc[c_IDX_BITS+1:2];
    assign w_f_tag    = fetch_pc[c_IDX_BITS+2 +: TAG_BITS];
    assign w_f_hit    = (r_state == c_ST_IDLE) && r_valid[w_f_idx] &&
                        (r_tag[w_f_idx] == w_f_tag);
    assign w_f_taken  = w_f_hit && r_ctr[w_f_idx][CTR_BITS-1];
    assign w_f_target = w_f_taken ? r_target[w_f_idx] : (fetch_pc + XLEN'(4));

    // Prediction registers; outputs hold when no lookup is requested
    always_ff @(posedge clk) begin
        if (rst) begin
            pred_valid  <= 1'b0;
            pred_hit    <= 1'b0;
            pred_taken  <= 1'b0;
            pred_target <= '0;
        end else if (fetch_valid) begin
            pred_valid  <= 1'b1;
            pred_hit    <= w_f_hit;
            pred_taken  <= w_f_taken;
            pred_target <= w_f_target;
        end else begin
            pred_valid  <= 1'b0;
        end
    end

    // Training path; flush beats a same-cycle update
    assign w_u_idx = update_pc[c_IDX_BITS+1:2];
    assign w_u_tag = update_pc[c_IDX_BITS+2 +: TAG_BITS];
    assign w_u_hit = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);
    assign w_u_en  = !rst && (r_state == c_ST_IDLE) && update_valid && !flush;

    // Saturating counter step for a resident entry
    always_comb begin
        w_ctr_upd = r_ctr[w_u_idx];
        if (update_taken && (r_ctr[w_u_idx] != c_CTR_MAX)) begin
            w_ctr_upd = r_ctr[w_u_idx] + 1'b1;
        end else if (!update_taken && (r_ctr[w_u_idx] != '0)) begin
            w_ctr_upd = r_ctr[w_u_idx] - 1'b1;
        end
    end

    // Entry payload writes: train on hit, allocate on taken miss
    always_ff @(posedge clk) begin
        if (w_u_en) begin
            if (w_u_hit) begin
                r_ctr[w_u_idx] <= w_ctr_upd;
                if (update_taken) begin
                    r_target[w_u_idx] <= update_target;
                end
            end else if (update_taken) begin
                r_tag[w_u_idx]    <= w_u_tag;
                r_target[w_u_idx] <= update_target;
                r_ctr[w_u_idx]    <= c_CTR_WEAK;
            end
        end
    end

    // Valid bits: cleared by the walk, set by allocation
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_clear_en) begin
                r_valid[r_ptr] <= 1'b0;
            end else if (w_u_en && !w_u_hit && update_taken) begin
                r_valid[w_u_idx] <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor_bimodal_btb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_predictor_bimodal_btb
//  Description : Self-checking bench for branch_predictor_bimodal_btb:
//                directed table, hand-written walk/flush sequences and
//                randomized traffic against a behavioural table model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor_bimodal_btb;

    localparam int c_ENT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_valid;
    logic [63:0] fetch_pc;
    logic        pred_valid;
    logic        pred_hit;
    logic        pred_taken;
    logic [63:0] pred_target;
    logic        update_valid;
    logic [63:0] update_pc;
    logic        update_taken;
    logic [63:0] update_target;
    logic        flush;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Behavioural model: whole-table state, busy as a remaining-cycle count
    bit          m_valid [c_ENT];
    logic [63:0] m_tag   [c_ENT];
    logic [63:0] m_tgt   [c_ENT];
    int          m_ctr   [c_ENT];
    int          m_busy  = 16;
    bit          e_pv, e_hit, e_taken;
    logic [63:0] e_tgt;

    typedef struct {
        bit          uv;
        logic [63:0] upc;
        bit          ut;
        logic [63:0] utg;
        bit          fv;
        logic [63:0] fpc;
        bit          pv;
        bit          hit;
        bit          taken;
        logic [63:0] tgt;
    } vec_t;
    vec_t tbl [17];

    branch_predictor_bimodal_btb #(
        .XLEN(64), .ENTRIES(16), .TAG_BITS(16), .CTR_BITS(2)
    ) dut (
        .clk(clk), .rst(rst),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
        .pred_valid(pred_valid), .pred_hit(pred_hit),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .update_valid(update_valid), .update_pc(update_pc),
        .update_taken(update_taken), .update_target(update_target),
        .flush(flush), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    function automatic int midx(logic [63:0] pc);
        return int'((pc >> 2) % 64'd16);
    endfunction

    function automatic logic [63:0] mtag(logic [63:0] pc);
        return (pc >> 6) & 64'hFFFF;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // Advance the model by one clock with the given inputs
    task automatic model_step(input bit r, input bit fv, input logic [63:0] fpc,
                              input bit uv, input logic [63:0] upc, input bit ut,
                              input logic [63:0] utg, input bit fl);
        int fi, ui;
        bit h;
        if (r) begin
            e_pv = 0; e_hit = 0; e_taken = 0; e_tgt = 0;
            m_busy = 16;
            for (int i = 0; i < c_ENT; i++) m_valid[i] = 0;
            return;
        end
        if (fv) begin
            fi = midx(fpc);
            h = (m_busy == 0) && m_valid[fi] && (m_tag[fi] == mtag(fpc));
            e_pv = 1;
            e_hit = h;
            e_taken = h && (m_ctr[fi] >= 2);
            e_tgt = e_taken ? m_tgt[fi] : fpc + 64'd4;
        end else begin
            e_pv = 0;
        end
        if (m_busy > 0) begin
            m_busy = fl ? 16 : m_busy - 1;
        end else if (fl) begin
            m_busy = 16;
            for (int i = 0; i < c_ENT; i++) m_valid[i] = 0;
        end else if (uv) begin
            ui = midx(upc);
            if (m_valid[ui] && m_tag[ui] == mtag(upc)) begin
                m_ctr[ui] = ut ? ((m_ctr[ui] < 3) ? m_ctr[ui] + 1 : 3)
                               : ((m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0);
                if (ut) m_tgt[ui] = utg;
            end else if (ut) begin
                m_valid[ui] = 1;
                m_tag[ui]   = mtag(upc);
                m_tgt[ui]   = utg;
                m_ctr[ui]   = 2;
            end
        end
    endtask

    // Drive one cycle, then compare every output against the model
    task automatic cycle(input bit r, input bit fv, input logic [63:0] fpc,
                         input bit uv, input logic [63:0] upc, input bit ut,
                         input logic [63:0] utg, input bit fl);
        rst = r; fetch_valid = fv; fetch_pc = fpc;
        update_valid = uv; update_pc = upc; update_taken = ut; update_target = utg;
        flush = fl;
        model_step(r, fv, fpc, uv, upc, ut, utg, fl);
        @(posedge clk);
        #1;
        cyc++;
        chk("model_pred_valid", pred_valid, e_pv);
        chk("model_pred_hit", pred_hit, e_hit);
        chk("model_pred_taken", pred_taken, e_taken);
        chk("model_pred_target", pred_target, e_tgt);
        chk("model_busy", busy, m_busy > 0);
    endtask

    task automatic idle_cycle();
        cycle(0, 0, 64'h0, 0, 64'h0, 0, 64'h0, 0);
    endtask

    function automatic logic [63:0] rand_pc();
        logic [63:0] pc;
        if ($urandom_range(0, 9) == 0) begin
            pc = {$urandom, $urandom};
        end else begin
            pc = (64'($urandom_range(0, 3)) << 6) | (64'($urandom_range(0, 15)) << 2)
               | 64'($urandom_range(0, 3)) | 64'h10000;
        end
        return pc;
    endfunction

    initial begin
        int n;
        // Directed vectors, applied from an empty table after the first walk
        tbl[0]  = '{1, 64'h1000, 1, 64'h2000, 0, 64'h1000, 0, 0, 0, 64'h1004};
        tbl[1]  = '{0, 64'h0,    0, 64'h0,    1, 64'h1000, 1, 1, 1, 64'h2000};
        tbl[2]  = '{1, 64'h1000, 0, 64'h0,    1, 64'h1000, 1, 1, 1, 64'h2000};
        tbl[3]  = '{1, 64'h1000, 0, 64'h0,    1, 64'h1000, 1, 1, 0, 64'h1004};
        tbl[4]  = '{1, 64'h1000, 0, 64'h0,    1, 64'h1000, 1, 1, 0, 64'h1004};
        tbl[5]  = '{1, 64'h1000, 1, 64'h2000, 1, 64'h1000, 1, 1, 0, 64'h1004};
        tbl[6]  = '{0, 64'h0,    0, 64'h0,    1, 64'h1000, 1, 1, 0, 64'h1004};
        tbl[7]  = '{1, 64'h1000, 1, 64'h2000, 1, 64'h1000, 1, 1, 0, 64'h1004};
        tbl[8]  = '{0, 64'h0,    0, 64'h0,    1, 64'h1000, 1, 1, 1, 64'h2000};
        tbl[9]  = '{0, 64'h0,    0, 64'h0,    1, 64'h1040, 1, 0, 0, 64'h1044};
        tbl[10] = '{1, 64'h1040, 1, 64'h3000, 1, 64'h1040, 1, 0, 0, 64'h1044};
        tbl[11] = '{0, 64'h0,    0, 64'h0,    1, 64'h1000, 1, 0, 0, 64'h1004};
        tbl[12] = '{0, 64'h0,    0, 64'h0,    1, 64'h1040, 1, 1, 1, 64'h3000};
        tbl[13] = '{0, 64'h0,    0, 64'h0,    1, 64'hFFFFFFFFFFFFFFFC, 1, 0, 0, 64'h0};
        tbl[14] = '{0, 64'h0,    0, 64'h0,    0, 64'h0,    0, 0, 0, 64'h0};
        tbl[15] = '{1, 64'h1010, 1, 64'h5000, 1, 64'h1010, 1, 0, 0, 64'h1014};
        tbl[16] = '{0, 64'h0,    0, 64'h0,    1, 64'h1010, 1, 1, 1, 64'h5000};

        // Reset held 3 cycles with fetches: no predictions come out
        for (int i = 0; i < 3; i++) begin
            cycle(1, 1, 64'h1000, 0, 64'h0, 0, 64'h0, 0);
            chk("rst_pred_valid", pred_valid, 0);
            chk("rst_busy", busy, 1);
        end
        // Initial walk: exactly 16 busy cycles, every lookup forced to miss
        n = 0;
        while (busy && n < 40) begin
            cycle(0, 1, 64'h1000, 0, 64'h0, 0, 64'h0, 0);
            n++;
            chk("walk_pred_valid", pred_valid, 1);
            chk("walk_hit", pred_hit, 0);
            chk("walk_target", pred_target, 64'h1004);
        end
        chk("init_walk_len", n, 16);

        // Table of training/lookup vectors
        for (int i = 0; i < 17; i++) begin
            cycle(0, tbl[i].fv, tbl[i].fpc, tbl[i].uv, tbl[i].upc, tbl[i].ut, tbl[i].utg, 0);
            chk("tbl_pred_valid", pred_valid, tbl[i].pv);
            chk("tbl_hit", pred_hit, tbl[i].hit);
            chk("tbl_taken", pred_taken, tbl[i].taken);
            chk("tbl_target", pred_target, tbl[i].tgt);
        end

        // Fill index 0 and 5, then flush, restart mid-walk, ignore busy update
        cycle(0, 0, 64'h0, 1, 64'h1000, 1, 64'h2000, 0);
        cycle(0, 0, 64'h0, 1, 64'h1014, 1, 64'h4000, 0);
        cycle(0, 1, 64'h1014, 0, 64'h0, 0, 64'h0, 0);
        chk("fill_hit5", pred_hit, 1);
        cycle(0, 0, 64'h0, 0, 64'h0, 0, 64'h0, 1);
        chk("flush_busy", busy, 1);
        for (int i = 0; i < 7; i++) idle_cycle();
        cycle(0, 0, 64'h0, 0, 64'h0, 0, 64'h0, 1);
        n = 0;
        while (busy && n < 40) begin
            if (n == 11) cycle(0, 0, 64'h0, 1, 64'h1014, 1, 64'h7000, 0);
            else idle_cycle();
            n++;
        end
        chk("reflush_walk_len", n, 16);
        cycle(0, 1, 64'h1000, 0, 64'h0, 0, 64'h0, 0);
        chk("post_flush_hit0", pred_hit, 0);
        cycle(0, 1, 64'h1014, 0, 64'h0, 0, 64'h0, 0);
        chk("post_flush_hit5", pred_hit, 0);
        chk("post_flush_tgt5", pred_target, 64'h1018);

        // Same-cycle update and lookup: read-before-write
        cycle(0, 1, 64'h1000, 1, 64'h1000, 1, 64'h2000, 0);
        chk("rbw_hit", pred_hit, 0);
        chk("rbw_target", pred_target, 64'h1004);
        cycle(0, 1, 64'h1000, 0, 64'h0, 0, 64'h0, 0);
        chk("rbw_next_hit", pred_hit, 1);
        chk("rbw_next_target", pred_target, 64'h2000);

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 4) != 0, rand_pc(),
                  $urandom_range(0, 2) != 0, rand_pc(), 1'($urandom_range(0, 1)),
                  {$urandom, $urandom}, $urandom_range(0, 59) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
